smg_scan_capture: RTL and testbench
===================================

# smg_scan_capture

Six-digit seven-segment scan capture: samples the 10-bit multiplexed display bus (4-bit digit nibble plus 6-bit active-low digit select) and reassembles the 24-bit value being displayed. Sits on the display side of the scan driver, either for loopback self-check in the board test image or as the readback path for a bench monitor. It emits one validated 24-bit frame per complete, in-order scan of the six digits, and flags malformed scans.

## Interface
- T_STABLE, 13'd16 — cycles a bus value must hold unchanged before it is accepted (≥2).
- T_TIMEOUT, 13'd6000 — maximum cycles between accepted digits while collecting (used only with SMG_CAPTURE_TIMEOUT_EN).
- CLOCK  in  1  — system clock; all logic on rising edge.
- RESET  in  1  — asynchronous, active-high reset.
- iData  in  10  — scan bus {digit[3:0], sel[5:0]}; sel active-low one-hot.
- oData  out  24  — last complete frame; digit 0 at [23:20] … digit 5 at [3:0].
- oValid  out  1  — one-cycle pulse: oData updated this cycle.
- oErr  out  1  — one-cycle pulse: scan sequence error, frame discarded.

## Operation
- Select decode: 6'b111_110→index 0, 111_101→1, 111_011→2, 110_111→3, 101_111→4, 011_111→5. 6'b111_111 = blank (ignored, does not count as error, does not rearm). Any other pattern = illegal.
- Sampler: iData registered once (Q). Stability counter C (13 bits) clears when Q changes, else increments, saturating at T_STABLE-1. When C reaches T_STABLE-1 and the armed flag is set: generate one accept strobe and clear armed. Armed sets whenever Q changes. One accept per dwell regardless of dwell length.
- FSM states:
  - SYNC: ignore accepts except index 0; index 0 → store nibble in slot 0, expected k←1, go COLLECT. Illegal accepted → oErr, stay SYNC.
  - COLLECT: accept of index k → store nibble in slot k; if k<5, k←k+1; if k=5, oData←{slot0..slot4, nibble}, oValid pulse, go SYNC-ready with k←0 (i.e. next expected index 0, stays in COLLECT). Accept of wrong index or illegal → oErr, go SYNC; if the wrong index is 0, it is treated as a new frame start (slot 0 stored, k←1, COLLECT) in the same cycle as the oErr pulse.
- oData holds between frames; partial frames never reach oData.
- oValid and oErr never assert in the same cycle except the wrong-index-0 restart case (oErr only; oValid low).

## Timing
- Reset values: oData=24'h000000, oValid=0, oErr=0, Q=10'h3FF (blank), C=0, armed=0, state SYNC, k=0, slots 0.
- Latency: new bus value sampled into Q at edge n; accept at edge n+T_STABLE-1; oValid/oErr registered at edge n+T_STABLE.
- Values held fewer than T_STABLE cycles (glitch, ghosting during select transitions) are never accepted.
- RESET asserted mid-frame: immediate return to reset values, partial frame lost; first frame after release requires a full 0..5 scan.
- Counter saturates; no wrap-around for long dwells.

## Configuration
- SMG_CAPTURE_TIMEOUT_EN defined: watchdog counter in COLLECT with k≠0 counts cycles since last accept; at T_TIMEOUT-1 → oErr pulse, go SYNC, watchdog clears. Cleared on every accept and in SYNC.
- Not defined: no watchdog; COLLECT waits indefinitely (stopped scan holds state).

## Structure
- Package smg_pkg: select code constants (SEL_D0..SEL_D5, SEL_BLANK), FSM state encoding, digit-index-decode function (returns index plus illegal/blank flags).
- One sub-module: smg_stable_sampler (input register, stability counter, armed flag; outputs Q and accept strobe).

## Test plan
- T_STABLE=4: drive digits 1..6 in index order 0..5, 20-cycle dwells → oData=24'h123456, oValid single pulse 4 cycles after index 5 sampled, oErr never.
- Two consecutive scans of 24'hABCDEF then 24'h000999 → two oValid pulses, oData ABCDEF then 000999; long dwell (100 cycles) yields no duplicate accepts.
- 2-cycle glitch of sel=6'b110_111 inside index-1 dwell → ignored; frame completes normally.
- Order 0,1,3 → oErr pulse on the index-3 accept, no oValid; following clean scan 24'h654321 → oValid, correct data.
- Illegal sel 6'b111_100 held 10 cycles during COLLECT → oErr, return to SYNC; RESET pulsed after index 2 → all outputs zero, next full scan required for oValid.
- With SMG_CAPTURE_TIMEOUT_EN, T_TIMEOUT=50: stop after index 2 (bus blank) → oErr exactly at 50 cycles after last accept; without macro → no oErr.

Source files
------------

// File: rtl/smg_pkg.sv
// smg_pkg: shared constants, FSM encoding and select decode for smg_scan_capture.
//   SEL_D0..SEL_D5 : active-low one-hot digit selects, SEL_BLANK : all digits off
//   state_t        : capture FSM states
//   sel_decode()   : select pattern -> {digit index, illegal, blank}
package smg_pkg;

    localparam logic [5:0] SEL_D0    = 6'b111_110;
    localparam logic [5:0] SEL_D1    = 6'b111_101;
    localparam logic [5:0] SEL_D2    = 6'b111_011;
    localparam logic [5:0] SEL_D3    = 6'b110_111;
    localparam logic [5:0] SEL_D4    = 6'b101_111;
    localparam logic [5:0] SEL_D5    = 6'b011_111;
    localparam logic [5:0] SEL_BLANK = 6'b111_111;

    typedef enum logic {ST_SYNC, ST_COLLECT} state_t;

    typedef struct packed {
        logic [2:0] idx;
        logic       illegal;
        logic       blank;
    } sel_dec_t;

    function automatic sel_dec_t sel_decode(input logic [5:0] sel);
        sel_dec_t d;
        case (sel)
            SEL_D0:    d = '{3'd0, 1'b0, 1'b0};
            SEL_D1:    d = '{3'd1, 1'b0, 1'b0};
            SEL_D2:    d = '{3'd2, 1'b0, 1'b0};
            SEL_D3:    d = '{3'd3, 1'b0, 1'b0};
            SEL_D4:    d = '{3'd4, 1'b0, 1'b0};
            SEL_D5:    d = '{3'd5, 1'b0, 1'b0};
            SEL_BLANK: d = '{3'd0, 1'b0, 1'b1};
            default:   d = '{3'd0, 1'b1, 1'b0};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/smg_stable_sampler.sv
// smg_stable_sampler: registers the scan bus and emits one accept strobe per stable dwell.
//   clk, rst : clock, async active-high reset
//   d        : raw scan bus
//   q        : registered scan bus (resets to blank)
//   accept   : high for one cycle once q has held T_STABLE cycles since its last change
module smg_stable_sampler #(
    parameter logic [12:0] T_STABLE = 13'd16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] d,
    output logic [9:0] q,
    output logic       accept
);
    logic [12:0] c;
    logic        armed;
    logic        changed;

    assign changed = d != q;
    assign accept  = armed && c == T_STABLE - 13'd1;

    // armed re-sets on every change so a dwell produces exactly one accept,
    // while the counter saturates so long dwells never wrap into a second one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q     <= 10'h3FF;
            c     <= '0;
            armed <= 1'b0;
        end else begin
            q     <= d;
            c     <= changed ? '0 : (c == T_STABLE - 13'd1 ? c : c + 13'd1);
            armed <= changed | (armed & ~accept);
        end
    end

endmodule

// File: rtl/smg_scan_capture.sv
// smg_scan_capture: rebuilds the 24-bit displayed value from a 6-digit multiplexed scan bus.
//   CLOCK, RESET : clock, async active-high reset
//   iData        : {digit[3:0], sel[5:0]}, sel active-low one-hot
//   oData        : last complete frame, digit 0 at [23:20] .. digit 5 at [3:0]
//   oValid       : one-cycle pulse when oData is updated
//   oErr         : one-cycle pulse when a scan is malformed and discarded
// Define SMG_CAPTURE_TIMEOUT_EN to abort a stalled frame after T_TIMEOUT cycles.
module smg_scan_capture
    import smg_pkg::*;
#(
    parameter logic [12:0] T_STABLE  = 13'd16,
    parameter logic [12:0] T_TIMEOUT = 13'd6000
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [9:0]  iData,
    output logic [23:0] oData,
    output logic        oValid,
    output logic        oErr
);
    logic [9:0]       q;
    logic             accept;
    sel_dec_t         dec;
    logic [3:0]       nib;
    state_t           state, state_n;
    logic [2:0]       k, k_n;
    logic [5:0][3:0]  slots, slots_n;
    logic [23:0]      data_n;
    logic             valid_n, err_n;

    smg_stable_sampler #(.T_STABLE(T_STABLE)) u_sampler (
        .clk    (CLOCK),
        .rst    (RESET),
        .d      (iData),
        .q      (q),
        .accept (accept)
    );

    assign dec = sel_decode(q[5:0]);
    assign nib = q[9:6];

`ifdef SMG_CAPTURE_TIMEOUT_EN
    logic [12:0] wd, wd_n;
`else
    logic unused_timeout;
    assign unused_timeout = ^T_TIMEOUT;
`endif

    always_comb begin
        state_n = state;
        k_n     = k;
        slots_n = slots;
        data_n  = oData;
        valid_n = 1'b0;
        err_n   = 1'b0;
`ifdef SMG_CAPTURE_TIMEOUT_EN
        wd_n    = (state == ST_COLLECT && k != 3'd0) ? wd + 13'd1 : '0;
`endif
        if (accept && !dec.blank) begin
`ifdef SMG_CAPTURE_TIMEOUT_EN
            wd_n = '0;
`endif
            if (dec.illegal) begin
                err_n   = 1'b1;
                state_n = ST_SYNC;
                k_n     = 3'd0;
            end else if (state == ST_SYNC || dec.idx != k) begin
                // out-of-order digits are only errors once a frame is underway;
                // an index 0 always starts a fresh frame
                err_n = state == ST_COLLECT;
                if (dec.idx == 3'd0) begin
                    slots_n[0] = nib;
                    k_n        = 3'd1;
                    state_n    = ST_COLLECT;
                end else begin
                    k_n     = 3'd0;
                    state_n = ST_SYNC;
                end
            end else begin
                slots_n[k] = nib;
                if (k == 3'd5) begin
                    data_n  = {slots[0], slots[1], slots[2], slots[3], slots[4], nib};
                    valid_n = 1'b1;
                    k_n     = 3'd0;
                end else begin
                    k_n = k + 3'd1;
                end
            end
        end
`ifdef SMG_CAPTURE_TIMEOUT_EN
        else if (state == ST_COLLECT && k != 3'd0 && wd == T_TIMEOUT - 13'd1) begin
            err_n   = 1'b1;
            state_n = ST_SYNC;
            k_n     = 3'd0;
            wd_n    = '0;
        end
`endif
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state  <= ST_SYNC;
            k      <= 3'd0;
            slots  <= '0;
            oData  <= '0;
            oValid <= 1'b0;
            oErr   <= 1'b0;
`ifdef SMG_CAPTURE_TIMEOUT_EN
            wd     <= '0;
`endif
        end else begin
            state  <= state_n;
            k      <= k_n;
            slots  <= slots_n;
            oData  <= data_n;
            oValid <= valid_n;
            oErr   <= err_n;
`ifdef SMG_CAPTURE_TIMEOUT_EN
            wd     <= wd_n;
`endif
        end
    end

endmodule

// File: tb/tb_smg_scan_capture.sv
// tb_smg_scan_capture: self-checking bench for smg_scan_capture (T_STABLE=4, T_TIMEOUT=50).
module tb_smg_scan_capture;
    localparam logic [12:0] TS = 13'd4;
    localparam logic [12:0] TT = 13'd50;
`ifdef SMG_CAPTURE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic [9:0]  iData = 10'h3FF;
    logic [23:0] oData;
    logic        oValid;
    logic        oErr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        err;
        logic [23:0] data;
    } ev_t;
    ev_t sb[$];

    typedef struct {
        logic [23:0] value;
        int          dwell;
        logic [23:0] exp_data;
    } vec_t;
    vec_t vecs[3];

    logic [5:0] sel_code[6] = '{6'b111110, 6'b111101, 6'b111011, 6'b110111, 6'b101111, 6'b011111};

    smg_scan_capture #(.T_STABLE(TS), .T_TIMEOUT(TT)) dut (
        .CLOCK  (CLOCK),
        .RESET  (RESET),
        .iData  (iData),
        .oData  (oData),
        .oValid (oValid),
        .oErr   (oErr)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLOCK);
    endtask

    task automatic digit(input int idx, input logic [3:0] nib, input int dwell);
        iData = {nib, sel_code[idx]};
        tick(dwell);
    endtask

    task automatic scan(input logic [23:0] v, input int dwell);
        for (int i = 0; i < 6; i++) digit(i, v[23-4*i -: 4], dwell);
    endtask

    task automatic push(input logic err, input logic [23:0] d);
        sb.push_back('{err, d});
    endtask

    always @(negedge CLOCK) begin
        ev_t e;
        if (oValid || oErr) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event valid=%b err=%b data=%h required=none", oValid, oErr, oData);
            end else begin
                e = sb.pop_front();
                if (e.err) check("err_event", {oErr, oValid}, 2'b10);
                else check("valid_event", {oErr, oValid, oData}, {2'b01, e.data});
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{24'hABCDEF, 20, 24'hABCDEF};
        vecs[1] = '{24'h000999, 100, 24'h000999};
        vecs[2] = '{24'h654321, 20, 24'h654321};
        tick(3);
        check("reset_data", oData, 24'h0);
        check("reset_valid", oValid, 0);
        check("reset_err", oErr, 0);
        RESET = 1'b0;
        tick(2);

        push(1'b0, 24'h123456);
        for (int i = 0; i < 5; i++) digit(i, 4'(i + 1), 20);
        iData = {4'h6, sel_code[5]};
        for (int c = 1; c <= 7; c++) begin
            tick(1);
            check("valid_latency", oValid, c == 5);
        end
        tick(13);
        check("data_123456", oData, 24'h123456);

        foreach (vecs[i]) begin
            push(1'b0, vecs[i].exp_data);
            scan(vecs[i].value, vecs[i].dwell);
            check("table_data", oData, vecs[i].exp_data);
        end

        push(1'b0, 24'h13579B);
        digit(0, 4'h1, 20);
        digit(1, 4'h3, 2);
        iData = {4'h3, 6'b110111};
        tick(2);
        digit(1, 4'h3, 16);
        digit(2, 4'h5, 20);
        digit(3, 4'h7, 20);
        digit(4, 4'h9, 20);
        digit(5, 4'hB, 20);
        check("glitch_data", oData, 24'h13579B);

        push(1'b1, 24'h0);
        digit(0, 4'h6, 20);
        digit(1, 4'h5, 20);
        digit(3, 4'h4, 20);
        check("order_err_hold", oData, 24'h13579B);
        push(1'b0, 24'h654321);
        scan(24'h654321, 20);
        check("after_err_data", oData, 24'h654321);

        push(1'b1, 24'h0);
        push(1'b0, 24'h1A2B3C);
        digit(0, 4'h9, 20);
        digit(1, 4'h8, 20);
        scan(24'h1A2B3C, 20);
        check("restart_data", oData, 24'h1A2B3C);

        push(1'b1, 24'h0);
        digit(0, 4'h2, 20);
        digit(1, 4'h2, 20);
        iData = {4'h0, 6'b111100};
        tick(10);
        check("illegal_hold", oData, 24'h1A2B3C);

        digit(0, 4'h7, 20);
        digit(1, 4'h7, 20);
        digit(2, 4'h7, 20);
        RESET = 1'b1;
        tick(1);
        check("midreset_data", oData, 24'h0);
        check("midreset_valid", oValid, 0);
        check("midreset_err", oErr, 0);
        RESET = 1'b0;
        push(1'b1, 24'h0);
        iData = {4'h0, 6'b000000};
        tick(10);
        digit(3, 4'h7, 20);
        digit(4, 4'h7, 20);
        digit(5, 4'h7, 20);
        check("partial_after_reset", oData, 24'h0);
        push(1'b0, 24'h987654);
        scan(24'h987654, 20);
        check("after_reset_data", oData, 24'h987654);

        if (TO_EN) push(1'b1, 24'h0);
        digit(0, 4'h1, 20);
        digit(1, 4'h2, 20);
        iData = {4'h3, sel_code[2]};
        for (int c = 1; c <= 80; c++) begin
            tick(1);
            if (c == 20) iData = 10'h3FF;
            check("timeout_err", oErr, TO_EN && c == 55);
        end
        check("timeout_data", oData, 24'h987654);

        tick(10);
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
